// File: rtl/toggle_bank.sv
//============================================================================
// Module   : toggle_bank
// Purpose  : Multi-channel rate divider. Each channel counts its own
//            qualified `ready` cycles against one shared, loadable period.
//            At every period boundary the channel either toggles `out`
//            (toggle mode) or drives a one-cycle pulse on `out` (pulse mode),
//            and raises `done`.
// Ports    : clock     - system clock, rising edge
//            reset     - asynchronous active-low reset
//            ready     - per-channel advance qualifier
//            load      - latches period_in / mode_in, clears all counters
//            period_in - event period in qualified cycles (0 behaves as 1)
//            mode_in   - 0 = toggle, 1 = pulse
//            done_ack  - per-channel done acknowledge (sticky build only)
//            out       - per-channel toggle/pulse output, registered
//            done      - per-channel event flag, registered
//            busy      - any channel counter non-zero, registered
// Options  : TOGGLE_BANK_STICKY_DONE_EN - when defined, done[i] holds until
//            acknowledged through done_ack[i].
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module toggle_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] ready,
  input  logic                load,
  input  logic [CNT_W-1:0]    period_in,
  input  logic                mode_in,
`ifdef TOGGLE_BANK_STICKY_DONE_EN
  input  logic [CHANNELS-1:0] done_ack,
`endif
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] done,
  output logic                busy
);

  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);
  localparam logic [0:0]       C_MODE_TOGGLE = 1'b0;
  localparam logic [0:0]       C_MODE_PULSE  = 1'b1;

  logic [CNT_W-1:0]    r_period;
  logic [0:0]          r_mode;
  logic [CNT_W-1:0]    r_count [CHANNELS];
  logic [CHANNELS-1:0] r_out;
  logic [CHANNELS-1:0] r_done;
  logic                r_busy;

  logic [CNT_W-1:0]    w_count_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_fire;
  logic [CHANNELS-1:0] w_nonzero;
  logic [CHANNELS-1:0] w_out_nxt;
  logic [CHANNELS-1:0] w_done_nxt;
  logic [CNT_W-1:0]    w_last;
  logic [CNT_W-1:0]    w_period_sat;

  // Terminal count; r_period is never 0, so this never underflows.
  assign w_last       = r_period - C_ONE;
  assign w_period_sat = (period_in == '0) ? C_ONE : period_in;

  // Per-channel counter next state and event detection. A load cycle
  // suppresses every event and forces all counters back to 0.
  always_comb begin
    w_fire    = '0;
    w_nonzero = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_fire[i] = !load && ready[i] && (r_count[i] == w_last);
      if (load) begin
        w_count_nxt[i] = '0;
      end else if (ready[i]) begin
        w_count_nxt[i] = w_fire[i] ? '0 : (r_count[i] + C_ONE);
      end else begin
        w_count_nxt[i] = r_count[i];
      end
      w_nonzero[i] = (w_count_nxt[i] != '0);
    end
  end

  // Output and flag next state.
  always_comb begin
    w_out_nxt  = r_out;
    w_done_nxt = '0;
    if (load) begin
      // Toggle levels survive a reload; pulse outputs are dropped.
      w_out_nxt = (r_mode == C_MODE_PULSE) ? '0 : r_out;
    end else begin
      if (r_mode == C_MODE_PULSE) begin
        w_out_nxt = w_fire;
      end else begin
        w_out_nxt = r_out ^ w_fire;
      end
`ifdef TOGGLE_BANK_STICKY_DONE_EN
      // A new event wins over a simultaneous acknowledge.
      w_done_nxt = w_fire | (r_done & ~done_ack);
`else
      w_done_nxt = w_fire;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_period <= C_ONE;
      r_mode   <= C_MODE_TOGGLE;
      r_out    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      if (load) begin
        r_period <= w_period_sat;
        r_mode   <= mode_in;
      end
      r_out  <= w_out_nxt;
      r_done <= w_done_nxt;
      // Built from next-state counters so busy drops on the wrap edge itself.
      r_busy <= |w_nonzero;
      for (int i = 0; i < CHANNELS; i++) begin
        r_count[i] <= w_count_nxt[i];
      end
    end
  end

  assign out  = r_out;
  assign done = r_done;
  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_toggle_bank.sv
//============================================================================
// Module   : tb_toggle_bank
// Purpose  : Self-checking bench for toggle_bank. A reference model tracks,
//            per channel, the total number of qualified ready cycles since
//            the last load/reset; an event fires whenever that total reaches
//            a multiple of the period.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_toggle_bank;

  localparam int CH  = 4;
  localparam int CW  = 8;

  logic          clock;
  logic          reset;
  logic [CH-1:0] ready;
  logic          load;
  logic [CW-1:0] period_in;
  logic          mode_in;
  logic [CH-1:0] done_ack;
  logic [CH-1:0] out;
  logic [CH-1:0] done;
  logic          busy;

  toggle_bank #(.CHANNELS(CH), .CNT_W(CW)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .ready     (ready),
    .load      (load),
    .period_in (period_in),
    .mode_in   (mode_in),
`ifdef TOGGLE_BANK_STICKY_DONE_EN
    .done_ack  (done_ack),
`endif
    .out       (out),
    .done      (done),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int            m_tally [CH];
  int            m_period;
  bit            m_mode;
  logic [CH-1:0] m_out;
  logic [CH-1:0] m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) m_tally[i] = 0;
    m_period = 1;
    m_mode   = 1'b0;
    m_out    = '0;
    m_done   = '0;
  endtask

  function automatic logic model_busy();
    logic b = 1'b0;
    for (int i = 0; i < CH; i++) if ((m_tally[i] % m_period) != 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_step();
    bit sticky;
    bit ev;
`ifdef TOGGLE_BANK_STICKY_DONE_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
`endif
    if (!reset) begin
      model_reset();
    end else if (load) begin
      if (m_mode) m_out = '0;
      m_period = (period_in == 0) ? 1 : int'(period_in);
      m_mode   = mode_in;
      for (int i = 0; i < CH; i++) m_tally[i] = 0;
      m_done = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        ev = 1'b0;
        if (ready[i]) begin
          m_tally[i]++;
          ev = ((m_tally[i] % m_period) == 0);
        end
        if (m_mode) m_out[i] = ev;
        else if (ev) m_out[i] = ~m_out[i];
        if (sticky) m_done[i] = ev | (m_done[i] & ~done_ack[i]);
        else        m_done[i] = ev;
      end
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cyc(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check({tag, ".out"},  32'(out),  32'(m_out));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".busy"}, 32'(busy), 32'(model_busy()));
  endtask

  task automatic do_load(input int p, input bit m);
    load = 1'b1; period_in = CW'(p); mode_in = m;
    cyc("load");
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ready = '0; load = 1'b0; period_in = '0; mode_in = 1'b0; done_ack = '0;
    model_reset();
    #1 reset = 1'b0;
    #1;
    check("rst.out",  32'(out),  32'h0);
    check("rst.done", 32'(done), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    cyc("rst");
    cyc("rst");
    reset = 1'b1;

    // Legacy defaults: channel 0 flips every ready cycle.
    ready = 4'b0001;
    for (int k = 0; k < 4; k++) cyc("legacy");
    ready = '0;
    cyc("legacy_idle");

    // Divide-by-3 toggle on all channels.
    do_load(3, 1'b0);
    ready = 4'b1111;
    for (int k = 0; k < 9; k++) cyc("div3");
    ready = '0;

    // Pulse mode with gaps on channel 2.
    do_load(2, 1'b1);
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int k = 0; k < 6; k++) begin
        ready = {1'b0, pat[k], 2'b00};
        cyc("pulse");
      end
    end
    ready = '0;
    cyc("pulse_idle");

    // Load collides with a would-be event on channel 1.
    do_load(3, 1'b0);
    ready = 4'b0010;
    cyc("coll_pre");
    cyc("coll_pre");
    load = 1'b1; period_in = '0; mode_in = 1'b0;
    cyc("coll_load");
    load = 1'b0;
    cyc("coll_post");
    ready = '0;

    // Drive out to 1010 with counters running, then reset between edges.
    do_load(1, 1'b0);
    ready = m_out ^ 4'b1010;
    cyc("pre_arst");
    ready = '0;
    do_load(3, 1'b0);
    ready = 4'b1111;
    cyc("pre_arst");
    check("pre_arst.out", 32'(out), 32'hA);
    #3 reset = 1'b0;
    #1;
    check("arst.out",  32'(out),  32'h0);
    check("arst.done", 32'(done), 32'h0);
    check("arst.busy", 32'(busy), 32'h0);
    model_reset();
    cyc("arst_hold");
    ready = '0;
    reset = 1'b1;
    cyc("arst_rel");

`ifdef TOGGLE_BANK_STICKY_DONE_EN
    do_load(1, 1'b0);
    ready = 4'b0001;
    cyc("sticky_ev");
    ready = '0;
    for (int k = 0; k < 5; k++) cyc("sticky_hold");
    done_ack = 4'b0001;
    cyc("sticky_ack");
    done_ack = '0;
    cyc("sticky_clr");
    ready = 4'b0001;
    cyc("sticky_ev2");
    done_ack = 4'b0001;
    cyc("sticky_ack_ev");
    ready = '0; done_ack = '0;
    cyc("sticky_after");
`endif

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      load = ($urandom_range(15) == 0);
      case ($urandom_range(4))
        0:       period_in = '0;
        1:       period_in = CW'(1);
        2:       period_in = CW'(2);
        3:       period_in = CW'(3);
        default: period_in = CW'($urandom_range(7));
      endcase
      mode_in = 1'($urandom_range(1));
      ready   = CH'($urandom);
`ifdef TOGGLE_BANK_STICKY_DONE_EN
      done_ack = CH'($urandom);
`endif
      cyc("rand");
    end
    load = 1'b0; ready = '0; done_ack = '0;

    // Largest period: no wrap before the terminal count.
    do_load(255, 1'b0);
    ready = 4'b0001;
    for (int k = 0; k < 256; k++) cyc("p255");
    ready = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
